// File: rtl/data_mem_stream_pkg.sv
// Shared definitions for the serial data-memory address stream.
// Holds the receiver FSM state encoding, the default address width (must match
// the sender's PC width) and the bit-order constant shared with the ucpu
// address serialiser.
package data_mem_stream_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

  // Address bits travel MSB first on the wire.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/serial_shift_in.sv
// Serial-to-parallel shift register with frame bit counter.
// Ports:
//   sys_clk, sys_reset : clock, asynchronous active-high reset
//   start              : sample the first (MSB) bit of a frame, counter := 1
//   shift              : sample a following bit, counter increments
//   clear              : abandon the frame, counter := 0
//   serial_bit         : incoming serial bit
//   word_c             : word including the bit sampled this cycle
//   done_c             : this cycle's shift samples the last address bit
//   word               : registered shift contents (parity build only)
// Macro DATA_MEM_ADDR_PARITY_EN exposes the registered word for the parity check.
module serial_shift_in
  import data_mem_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  start,
  input  logic                  shift,
  input  logic                  clear,
  input  logic                  serial_bit,
  output logic [ADDR_WIDTH-1:0] word_c,
  output logic                  done_c
`ifdef DATA_MEM_ADDR_PARITY_EN
  ,
  output logic [ADDR_WIDTH-1:0] word
`endif
);

  localparam int unsigned CNT_WIDTH = $clog2(ADDR_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ADDR_WIDTH - 1);

  logic [ADDR_WIDTH-1:0] shift_reg;
  logic [CNT_WIDTH-1:0]  count;

  // Word as it will look after this edge, so a frame can commit on its last bit.
  assign word_c = MSB_FIRST ? {shift_reg[ADDR_WIDTH-2:0], serial_bit}
                            : {serial_bit, shift_reg[ADDR_WIDTH-1:1]};
  assign done_c = shift && (count == LAST_CNT);

`ifdef DATA_MEM_ADDR_PARITY_EN
  assign word = shift_reg;
`endif

  // Shift register and bit counter.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      shift_reg <= '0;
      count     <= '0;
    end else begin
      if (start || shift) begin
        shift_reg <= word_c;
      end
      if (clear) begin
        count <= '0;
      end else if (start) begin
        count <= CNT_WIDTH'(1);
      end else if (shift) begin
        count <= done_c ? '0 : count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/data_mem_addr_deserialise.sv
// Memory-side receiver for the serial data-memory address stream.
// Reassembles ADDR_WIDTH MSB-first bits into a parallel address presented on a
// valid/ready output, flagging truncated frames and dropped (overrun) frames.
// Ports:
//   sys_clk, sys_reset : clock, asynchronous active-high reset
//   stream_en          : frame-active qualifier from the sender
//   stream_bit         : serial address bit, MSB first
//   addr_out           : last completed address
//   addr_valid         : addr_out holds an unconsumed address
//   addr_ready         : consumer accepts addr_out when addr_valid is high
//   frame_err          : one-cycle pulse, stream_en dropped mid-frame
//   overrun            : sticky, a completed frame was dropped while addr_valid pending
//   err_clr            : synchronous clear of the sticky error flags
//   busy               : a frame is in progress
//   parity_err         : sticky parity mismatch (DATA_MEM_ADDR_PARITY_EN only)
// Macro DATA_MEM_ADDR_PARITY_EN adds a trailing even-parity bit per frame.
module data_mem_addr_deserialise
  import data_mem_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  stream_en,
  input  logic                  stream_bit,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  err_clr,
  output logic                  busy
`ifdef DATA_MEM_ADDR_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  state_e                state;
  state_e                state_nxt;
  logic                  start_c;
  logic                  shift_c;
  logic                  clear_c;
  logic                  commit_c;
  logic                  trunc_c;
  logic                  overrun_set_c;
  logic [ADDR_WIDTH-1:0] word_c;
  logic [ADDR_WIDTH-1:0] commit_word_c;
  logic                  done_c;
`ifdef DATA_MEM_ADDR_PARITY_EN
  logic [ADDR_WIDTH-1:0] word;
  logic                  par_bad_c;
`endif

  serial_shift_in #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_shift (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .start      (start_c),
    .shift      (shift_c),
    .clear      (clear_c),
    .serial_bit (stream_bit),
    .word_c     (word_c),
    .done_c     (done_c)
`ifdef DATA_MEM_ADDR_PARITY_EN
    ,
    .word       (word)
`endif
  );

  // State register.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt     = state;
    start_c       = 1'b0;
    shift_c       = 1'b0;
    clear_c       = 1'b0;
    commit_c      = 1'b0;
    trunc_c       = 1'b0;
    commit_word_c = word_c;
`ifdef DATA_MEM_ADDR_PARITY_EN
    par_bad_c     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (stream_en) begin
          start_c   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (stream_en) begin
          shift_c = 1'b1;
          if (done_c) begin
`ifdef DATA_MEM_ADDR_PARITY_EN
            state_nxt = PARITY;
`else
            commit_c  = 1'b1;
            state_nxt = IDLE;
`endif
          end
        end else begin
          clear_c   = 1'b1;
          trunc_c   = 1'b1;
          state_nxt = IDLE;
        end
      end
`ifdef DATA_MEM_ADDR_PARITY_EN
      PARITY: begin
        state_nxt = IDLE;
        if (stream_en) begin
          // Even parity: address bits plus parity bit must XOR to zero.
          commit_word_c = word;
          if ((^word ^ stream_bit) == 1'b0) begin
            commit_c = 1'b1;
          end else begin
            par_bad_c = 1'b1;
          end
        end else begin
          trunc_c = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    overrun_set_c = commit_c && addr_valid && !addr_ready;
  end

  // Output register, handshake and error flags.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      addr_out   <= '0;
      addr_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= trunc_c;
      busy      <= (state_nxt != IDLE);
      // Set wins over a simultaneous clear.
      overrun   <= (overrun && !err_clr) || overrun_set_c;
      if (commit_c && (!addr_valid || addr_ready)) begin
        addr_out   <= commit_word_c;
        addr_valid <= 1'b1;
      end else if (addr_valid && addr_ready) begin
        addr_valid <= 1'b0;
      end
    end
  end

`ifdef DATA_MEM_ADDR_PARITY_EN
  // Sticky parity error, set wins over clear.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (parity_err && !err_clr) || par_bad_c;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_addr_deserialise.sv
// Directed bench for data_mem_addr_deserialise (ADDR_WIDTH = 8).
module tb_data_mem_addr_deserialise;

`ifdef DATA_MEM_ADDR_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       sys_clk;
  logic       sys_reset;
  logic       stream_en;
  logic       stream_bit;
  logic [7:0] addr_out;
  logic       addr_valid;
  logic       addr_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;
`ifdef DATA_MEM_ADDR_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  data_mem_addr_deserialise #(
    .ADDR_WIDTH (8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .stream_en  (stream_en),
    .stream_bit (stream_bit),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .busy       (busy)
`ifdef DATA_MEM_ADDR_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one full frame; addr_ready is raised only on the committing edge
  // when ready_last is set. stream_en stays high afterwards unless drop_en.
  task automatic send_frame(input logic [7:0] v, input bit bad_par,
                            input bit ready_last, input bit drop_en);
    for (int i = 7; i >= 0; i--) begin
      stream_en  = 1'b1;
      stream_bit = v[i];
      addr_ready = ready_last && (i == 0) && !PAR;
      tick();
    end
    if (PAR) begin
      stream_bit = (^v) ^ bad_par;
      addr_ready = ready_last;
      tick();
    end
    addr_ready = 1'b0;
    if (drop_en) stream_en = 1'b0;
  endtask

  initial begin
    sys_reset  = 1'b1;
    stream_en  = 1'b0;
    stream_bit = 1'b0;
    addr_ready = 1'b0;
    err_clr    = 1'b0;
    tick();
    tick();
    check("rst_addr_out",   addr_out, 8'h00);
    check("rst_addr_valid", {7'd0, addr_valid}, 8'd0);
    check("rst_frame_err",  {7'd0, frame_err}, 8'd0);
    check("rst_overrun",    {7'd0, overrun}, 8'd0);
    check("rst_busy",       {7'd0, busy}, 8'd0);
    sys_reset = 1'b0;
    tick();

    // Reset asserted between edges after 3 bits of a frame.
    for (int i = 0; i < 3; i++) begin
      stream_en  = 1'b1;
      stream_bit = 1'b1;
      tick();
    end
    check("midframe_busy_before", {7'd0, busy}, 8'd1);
    #3;
    sys_reset = 1'b1;
    #1;
    check("midframe_busy_async",  {7'd0, busy}, 8'd0);
    check("midframe_valid_async", {7'd0, addr_valid}, 8'd0);
    check("midframe_addr_async",  addr_out, 8'h00);
    stream_en = 1'b0;
    #1;
    sys_reset = 1'b0;
    tick();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check("after_rst_addr",  addr_out, 8'h3C);
    check("after_rst_valid", {7'd0, addr_valid}, 8'd1);
    addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    check("drain_3c_valid", {7'd0, addr_valid}, 8'd0);
    check("drain_3c_hold",  addr_out, 8'h3C);

    // Single frame 0xA5 then one-cycle acceptance.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_addr",  addr_out, 8'hA5);
    check("a5_valid", {7'd0, addr_valid}, 8'd1);
    check("a5_busy",  {7'd0, busy}, 8'd0);
    addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    check("a5_accept_valid", {7'd0, addr_valid}, 8'd0);

    // Back-to-back 0x12, 0x34 with acceptance on the 0x34 commit edge.
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    check("b2b_first_addr", addr_out, 8'h12);
    check("b2b_first_busy", {7'd0, busy}, 8'd0);
    send_frame(8'h34, 1'b0, 1'b1, 1'b1);
    check("b2b_addr",    addr_out, 8'h34);
    check("b2b_valid",   {7'd0, addr_valid}, 8'd1);
    check("b2b_overrun", {7'd0, overrun}, 8'd0);
    addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    check("b2b_drain_valid", {7'd0, addr_valid}, 8'd0);

    // Overrun: 0x55 left pending, 0xAA dropped.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("ovr_first_overrun", {7'd0, overrun}, 8'd0);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    check("ovr_addr_kept", addr_out, 8'h55);
    check("ovr_valid",     {7'd0, addr_valid}, 8'd1);
    check("ovr_flag",      {7'd0, overrun}, 8'd1);
    tick();
    check("ovr_sticky",    {7'd0, overrun}, 8'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_cleared",   {7'd0, overrun}, 8'd0);
    check("ovr_clr_valid", {7'd0, addr_valid}, 8'd1);
    addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    check("ovr_drain_valid", {7'd0, addr_valid}, 8'd0);

    // Truncation after 5 bits.
    for (int i = 0; i < 5; i++) begin
      stream_en  = 1'b1;
      stream_bit = 1'b0;
      tick();
    end
    stream_en = 1'b0;
    tick();
    check("trunc_frame_err", {7'd0, frame_err}, 8'd1);
    check("trunc_valid",     {7'd0, addr_valid}, 8'd0);
    check("trunc_busy",      {7'd0, busy}, 8'd0);
    check("trunc_addr",      addr_out, 8'h55);
    tick();
    check("trunc_pulse_end", {7'd0, frame_err}, 8'd0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    check("ff_addr",      addr_out, 8'hFF);
    check("ff_valid",     {7'd0, addr_valid}, 8'd1);
    check("ff_frame_err", {7'd0, frame_err}, 8'd0);
    addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    check("ff_drain_valid", {7'd0, addr_valid}, 8'd0);

`ifdef DATA_MEM_ADDR_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1.
    send_frame(8'h07, 1'b0, 1'b0, 1'b1);
    check("par_ok_addr",  addr_out, 8'h07);
    check("par_ok_valid", {7'd0, addr_valid}, 8'd1);
    check("par_ok_err",   {7'd0, parity_err}, 8'd0);
    addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check("par_bad_err",   {7'd0, parity_err}, 8'd1);
    check("par_bad_valid", {7'd0, addr_valid}, 8'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("par_err_clr", {7'd0, parity_err}, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_addr_deserialise.md
Name: data_mem_addr_deserialise

Overview:
Memory-side receiver for the serial data-memory address stream that the CPU drives MSB-first while it is in the SEND_PC state. It reassembles ADDR_WIDTH bits into a parallel address and presents it on a valid/ready output. It flags truncated frames and unconsumed-address overruns. It sits in the memory/harness wrapper, the far end of the ucpu address serialiser.

Parameters:
ADDR_WIDTH, 8, address bits per frame; must equal `PC_WIDTH of the sender; power of two, >= 2.
CNT_WIDTH, $clog2(ADDR_WIDTH), width of the bit counter (derived; do not override).

Ports:
sys_clk  input  1  system clock, all state on rising edge.
sys_reset  input  1  asynchronous, active-high reset.
stream_en  input  1  frame-active qualifier (high while the sender is in SEND_PC).
stream_bit  input  1  serial address bit, MSB first.
addr_out  output  ADDR_WIDTH  last completed address.
addr_valid  output  1  addr_out holds an unconsumed address.
addr_ready  input  1  consumer accepts addr_out when addr_valid && addr_ready.
frame_err  output  1  one-cycle pulse: stream_en dropped mid-frame.
overrun  output  1  sticky: a completed frame was dropped because addr_valid was still pending.
err_clr  input  1  synchronous clear of overrun.
busy  output  1  a frame is in progress (state SHIFT, or PARITY when enabled).

Behaviour:
- Reset (asynchronous, immediate): state IDLE, bit counter 0, shift register 0, addr_out 0, addr_valid 0, frame_err 0, overrun 0, busy 0. Reset mid-frame discards the partial frame with no error.
- FSM states: IDLE, SHIFT, plus PARITY when the option is enabled.
- IDLE:
  - stream_en=1 samples stream_bit as the MSB, sets counter to 1 and moves to SHIFT.
  - stream_en=0 stays in IDLE.
- SHIFT: each cycle with stream_en=1:
  - shift_reg <= {shift_reg[ADDR_WIDTH-2:0], stream_bit}; counter increments.
  - Sampling bit ADDR_WIDTH-1 (counter == ADDR_WIDTH-1) completes the frame:
    - the full word is committed at that same edge;
    - addr_valid is high from the next cycle, so latency is zero cycles after the last bit;
    - next state is IDLE, or PARITY if enabled.
- Back-to-back frames: if stream_en stays high after a completed frame, the next bit is the MSB of a new frame. IDLE's start rule applies in that same cycle, so there is no gap cycle.
- Truncated frame: stream_en=0 in SHIFT:
  - frame_err pulses for exactly one cycle;
  - counter is cleared, state returns to IDLE;
  - addr_out and addr_valid are unchanged.
- Commit rules on frame completion:
  - addr_valid=0 → load addr_out, set addr_valid.
  - addr_valid=1 and addr_ready=1 in the same cycle → load the new address, addr_valid stays 1, no overrun.
  - addr_valid=1 and addr_ready=0 → keep the old addr_out, set overrun.
- Handshake: addr_valid && addr_ready with no commit that cycle → addr_valid clears at the next edge. addr_out holds its value after acceptance.
- overrun:
  - cleared only by err_clr or reset;
  - if err_clr and a new overrun occur in the same cycle, set wins.
- busy is high in SHIFT (and PARITY), low in IDLE.

Optional Feature:
Macro DATA_MEM_ADDR_PARITY_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the LSB, sampled in PARITY while stream_en=1.
  - The commit happens on the parity edge, only if the XOR of the address bits and the parity bit is 0.
  - A parity mismatch drops the frame and raises a sticky parity_err output, cleared by err_clr.
  - stream_en low in PARITY counts as a truncated frame (frame_err).
- Undefined: no PARITY state, no parity_err port; frames are exactly ADDR_WIDTH bits.

Decomposition:
- Package data_mem_stream_pkg holds:
  - the FSM state enum (IDLE, SHIFT, PARITY);
  - the default address width, tied to `PC_WIDTH;
  - the MSB-first bit-order constant, shared with the serialiser.
- One sub-module, serial_shift_in: shift register plus bit counter, with a done strobe at count ADDR_WIDTH-1.
- The top module owns the FSM, the output register and handshake, and the error flags.

Test Plan:
- Reset mid-frame: after 3 bits, assert sys_reset asynchronously between edges → all outputs 0 immediately; the next full frame 0x3C decodes correctly.
- Frame 0xA5: stream_en high for 8 cycles, bits 1,0,1,0,0,1,0,1 → addr_out=0xA5, addr_valid=1 in cycle 9. Hold addr_ready=1 one cycle → addr_valid=0.
- Back-to-back: 0x12 then 0x34 with stream_en high for 16 cycles and addr_ready=1 on the cycle 0x34 completes → addr_out=0x34, addr_valid=1, overrun=0.
- Overrun: send 0x55 with no addr_ready, then 0xAA → addr_out stays 0x55, overrun=1. Pulse err_clr → overrun=0.
- Truncation: stream_en drops after 5 bits → frame_err high for one cycle, addr_valid unchanged, busy=0. The following full frame 0xFF decodes.
- Parity (macro defined): 0x07 with parity bit 1 → accepted. 0x07 with parity bit 0 → parity_err=1, addr_valid stays 0.
